hazard_ctrl_unit: RTL and testbench

Parametrised hazard controller for the five-stage RV32I pipeline. Detects load-use and, when forwarding is disabled, general RAW hazards between ID and later stages. Holds multi-cycle load stalls and freezes the pipeline on data-memory wait states. Flushes wrong-path instructions on a taken branch, generates EX-stage forwarding selects, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_ctrl_unit.sv | 198 +++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the five-stage RV32I pipeline: load-use and RAW
// stall detection, multi-cycle load stall sequencing, data-memory wait
// freeze, branch flush, EX-stage forwarding selects and a stall counter.
module hazard_ctrl_unit #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned FORWARDING   = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,

    input  logic [REG_ADDR_W-1:0] ex_rs1_i,
    input  logic [REG_ADDR_W-1:0] ex_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_reg_write_i,

    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_reg_write_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ready_i,

    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_reg_write_i,

    input  logic                  branch_taken_i,

    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  idex_write_o,
    output logic                  exmem_write_o,
    output logic                  idex_bubble_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    localparam int unsigned LAT_W = 4;

    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_LOAD_STALL = 1'b1;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    localparam logic [LAT_W-1:0] LOAD_STALL_INIT = LAT_W'(LOAD_LATENCY - 1);
    localparam logic             MULTI_CYCLE     = (LOAD_LATENCY > 1);
    localparam logic             FWD_EN          = (FORWARDING != 0);

    logic [0:0]       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic             lu_hazard;
    logic             raw_hazard;
    logic             mem_wait;
    logic             stall_req;

    // Producer/consumer match: producer writes, destination is not x0, indices equal.
    function automatic logic reg_match(input logic                  prod_en,
                                       input logic [REG_ADDR_W-1:0] prod_rd,
                                       input logic [REG_ADDR_W-1:0] cons_rs);
        return prod_en && (prod_rd != '0) && (prod_rd == cons_rs);
    endfunction

    // Hazard detection against the instruction currently in ID.
    always_comb begin
        logic ex_hit;
        logic mem_hit;

        lu_hazard = (id_use_rs1_i && reg_match(ex_mem_read_i, ex_rd_i, id_rs1_i))
                 || (id_use_rs2_i && reg_match(ex_mem_read_i, ex_rd_i, id_rs2_i));

        ex_hit  = (id_use_rs1_i && reg_match(ex_reg_write_i, ex_rd_i, id_rs1_i))
               || (id_use_rs2_i && reg_match(ex_reg_write_i, ex_rd_i, id_rs2_i));
        mem_hit = (id_use_rs1_i && reg_match(mem_reg_write_i, mem_rd_i, id_rs1_i))
               || (id_use_rs2_i && reg_match(mem_reg_write_i, mem_rd_i, id_rs2_i));

        // Write-first register file: a WB producer never needs a stall.
        raw_hazard = !FWD_EN && (lu_hazard || ex_hit || mem_hit);

        mem_wait  = mem_req_i && !mem_ready_i;
        stall_req = (state_q == ST_LOAD_STALL) || lu_hazard || raw_hazard;
    end

    // Load-stall sequencer: next state and remaining stall cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!mem_wait && !branch_taken_i && lu_hazard && MULTI_CYCLE) begin
                    state_d = ST_LOAD_STALL;
                    cnt_d   = LOAD_STALL_INIT;
                end
            end
            ST_LOAD_STALL: begin
                if (mem_wait) begin
                    state_d = state_q;
                    cnt_d   = cnt_q;
                end else if (branch_taken_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pipeline enables, bubble and flush by priority: wait > branch > stall > normal.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_write_o  = 1'b1;
        exmem_write_o = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;

        if (reset_i) begin
            pc_write_o = 1'b1;
        end else if (mem_wait) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (stall_req) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    // EX-stage forwarding selects; the younger EX/MEM producer wins.
    always_comb begin
        forward_a_o = FWD_REGFILE;
        forward_b_o = FWD_REGFILE;

        if (FWD_EN && !reset_i) begin
            if (reg_match(mem_reg_write_i, mem_rd_i, ex_rs1_i)) begin
                forward_a_o = FWD_EXMEM;
            end else if (reg_match(wb_reg_write_i, wb_rd_i, ex_rs1_i)) begin
                forward_a_o = FWD_MEMWB;
            end

            if (reg_match(mem_reg_write_i, mem_rd_i, ex_rs2_i)) begin
                forward_b_o = FWD_EXMEM;
            end else if (reg_match(wb_reg_write_i, wb_rd_i, ex_rs2_i)) begin
                forward_b_o = FWD_MEMWB;
            end
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write_o && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State, stall counter and statistics registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: three parameterisations share
// one stimulus stream and are checked against a cycle-level reference model.
module tb_hazard_ctrl_unit;

    localparam int unsigned N = 3;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write;
    logic       mem_reg_write, mem_req, mem_ready, wb_reg_write, branch_taken;

    // Per instance: {pc, ifid, idex, exmem, bubble, ifid_flush, idex_flush, fa, fb}
    logic [10:0] o_vec [N];
    logic [15:0] sc    [N];

    int LL [N] = '{1, 3, 1};
    int FW [N] = '{1, 1, 0};
    int CW [N] = '{16, 4, 16};

    int rem [N];
    int scm [N];
    int tests;
    int fails;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned P_LL = (g == 1) ? 3 : 1;
        localparam int unsigned P_FW = (g == 2) ? 0 : 1;
        localparam int unsigned P_CW = (g == 1) ? 4 : 16;
        logic pc_w, ifid_w, idex_w, exmem_w, bub, ifl, idfl;
        logic [1:0] fa, fb;
        logic [P_CW-1:0] cnt;

        hazard_ctrl_unit #(
            .REG_ADDR_W  (5),
            .LOAD_LATENCY(P_LL),
            .FORWARDING  (P_FW),
            .CNT_W       (P_CW)
        ) u_dut (
            .clk_i          (clk),
            .reset_i        (reset),
            .id_rs1_i       (id_rs1),
            .id_rs2_i       (id_rs2),
            .id_use_rs1_i   (id_use_rs1),
            .id_use_rs2_i   (id_use_rs2),
            .ex_rs1_i       (ex_rs1),
            .ex_rs2_i       (ex_rs2),
            .ex_rd_i        (ex_rd),
            .ex_mem_read_i  (ex_mem_read),
            .ex_reg_write_i (ex_reg_write),
            .mem_rd_i       (mem_rd),
            .mem_reg_write_i(mem_reg_write),
            .mem_req_i      (mem_req),
            .mem_ready_i    (mem_ready),
            .wb_rd_i        (wb_rd),
            .wb_reg_write_i (wb_reg_write),
            .branch_taken_i (branch_taken),
            .pc_write_o     (pc_w),
            .ifid_write_o   (ifid_w),
            .idex_write_o   (idex_w),
            .exmem_write_o  (exmem_w),
            .idex_bubble_o  (bub),
            .ifid_flush_o   (ifl),
            .idex_flush_o   (idfl),
            .forward_a_o    (fa),
            .forward_b_o    (fb),
            .stall_count_o  (cnt)
        );

        assign o_vec[g] = {pc_w, ifid_w, idex_w, exmem_w, bub, ifl, idfl, fa, fb};
        assign sc[g]    = 16'(cnt);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic hit(input logic en, input logic [4:0] rd, input logic [4:0] rs);
        return en && (rd != 5'd0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hit(mem_reg_write, mem_rd, rs)) return 2'b10;
        if (hit(wb_reg_write, wb_rd, rs))   return 2'b01;
        return 2'b00;
    endfunction

    // Compare every instance against the model for the current inputs, then advance the model.
    task automatic tick();
        #1;
        for (int k = 0; k < N; k++) begin
            logic lu, raw, mw, used_ex, used_mem;
            logic [10:0] exp;
            logic [1:0] fa, fb;
            int sat;
            sat = (1 << CW[k]) - 1;
            lu  = (id_use_rs1 && hit(ex_mem_read, ex_rd, id_rs1))
               || (id_use_rs2 && hit(ex_mem_read, ex_rd, id_rs2));
            used_ex  = (id_use_rs1 && hit(ex_reg_write, ex_rd, id_rs1))
                    || (id_use_rs2 && hit(ex_reg_write, ex_rd, id_rs2));
            used_mem = (id_use_rs1 && hit(mem_reg_write, mem_rd, id_rs1))
                    || (id_use_rs2 && hit(mem_reg_write, mem_rd, id_rs2));
            raw = (FW[k] == 0) && (lu || used_ex || used_mem);
            mw  = mem_req && !mem_ready;
            fa  = (FW[k] != 0) ? fwd_sel(ex_rs1) : 2'b00;
            fb  = (FW[k] != 0) ? fwd_sel(ex_rs2) : 2'b00;

            check_val($sformatf("cnt%0d", k), 32'(sc[k]), 32'(scm[k]));

            if (reset) begin
                exp = {7'b1111000, 4'b0000};
                rem[k] = 0;
                scm[k] = 0;
            end else if (mw) begin
                exp = {7'b0000000, fa, fb};
                if (scm[k] < sat) scm[k]++;
            end else if (branch_taken) begin
                exp = {7'b1111011, fa, fb};
                rem[k] = 0;
            end else if (rem[k] > 0 || lu || raw) begin
                exp = {7'b0011100, fa, fb};
                if (rem[k] > 0) rem[k]--;
                else if (lu)    rem[k] = LL[k] - 1;
                if (scm[k] < sat) scm[k]++;
            end else begin
                exp = {7'b1111000, fa, fb};
            end
            check_val($sformatf("out%0d", k), 32'(o_vec[k]), 32'(exp));
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        reset = 0; branch_taken = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0;
        mem_rd = 0; mem_reg_write = 0; mem_req = 0; mem_ready = 1;
        wb_rd = 0; wb_reg_write = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
        id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 1;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        for (int k = 0; k < N; k++) begin rem[k] = 0; scm[k] = 0; end
        clear_inputs();
        reset = 1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        tick();

        // lw x5 / add x6,x5,x7 with two memory-wait cycles in the middle of the stall
        clear_inputs(); set_load_use();
        #1 check_val("lu_stall", 32'(o_vec[0][10]), 32'd0);
        tick();
        clear_inputs(); ex_rs1 = 5; wb_rd = 5; wb_reg_write = 1;
        #1 check_val("fwd_a_01", 32'(o_vec[0][3:2]), 32'b01);
        tick();
        clear_inputs(); mem_req = 1; mem_ready = 0; tick();
        clear_inputs(); mem_req = 1; mem_ready = 0; tick();
        clear_inputs(); tick();
        clear_inputs();
        #1 check_val("ll3_count5", 32'(sc[1]), 32'd5);
        check_val("ll1_count3", 32'(sc[0]), 32'd3);
        tick();

        // x0 destination never stalls; EX/MEM beats MEM/WB
        clear_inputs(); ex_mem_read = 1; id_rs1 = 0; id_use_rs1 = 1;
        mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1; ex_rs2 = 3;
        #1 check_val("x0_nostall", 32'(o_vec[1][10]), 32'd1);
        check_val("fwd_b_10", 32'(o_vec[0][1:0]), 32'b10);
        tick();

        // branch coincident with load-use: flush only
        clear_inputs(); set_load_use(); branch_taken = 1;
        #1 check_val("br_lu_flush", 32'(o_vec[1][5:4]), 32'b11);
        tick();
        clear_inputs();
        #1 check_val("br_lu_nostall", 32'(o_vec[1][10]), 32'd1);
        tick();

        // branch while the LATENCY=3 stall still has two cycles left
        clear_inputs(); set_load_use(); tick();
        clear_inputs(); branch_taken = 1; tick();
        clear_inputs(); tick();

        // no forwarding: RAW stall until the producer leaves MEM
        clear_inputs(); ex_reg_write = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1; ex_rs1 = 1;
        #1 check_val("raw_ex", 32'(o_vec[2][10]), 32'd0);
        tick();
        clear_inputs(); mem_reg_write = 1; mem_rd = 4; id_rs1 = 4; id_use_rs1 = 1; ex_rs1 = 4;
        #1 check_val("raw_fwd00", 32'(o_vec[2][3:2]), 32'b00);
        tick();
        clear_inputs(); wb_reg_write = 1; wb_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
        #1 check_val("raw_wb_go", 32'(o_vec[2][10]), 32'd1);
        tick();

        // reset in the middle of a load stall and of a memory wait
        clear_inputs(); set_load_use(); tick();
        clear_inputs(); reset = 1; tick();
        clear_inputs(); check_val("rst_ls_cnt", 32'(sc[1]), 32'd0); tick();
        clear_inputs(); mem_req = 1; mem_ready = 0; tick();
        clear_inputs(); mem_req = 1; mem_ready = 0; reset = 1; tick();
        clear_inputs();
        #1 check_val("rst_mw_out", 32'(o_vec[0]), 32'h780);
        tick();

        // randomized traffic on a small register window to make matches frequent
        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 79) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom);
            id_use_rs2    = 1'($urandom);
            ex_rs1        = 5'($urandom_range(0, 3));
            ex_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_reg_write  = 1'($urandom);
            mem_rd        = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom);
            mem_req       = 1'($urandom);
            mem_ready     = ($urandom_range(0, 3) != 0);
            wb_rd         = 5'($urandom_range(0, 3));
            wb_reg_write  = 1'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
